// File: rtl/alu_branch_control_pkg.sv
// Shared types and constants for the ALU / branch-compare / control-decode stage.
package alu_branch_control_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'h0,
    ALU_SUB    = 4'h1,
    ALU_SLL    = 4'h2,
    ALU_SLT    = 4'h3,
    ALU_SLTU   = 4'h4,
    ALU_XOR    = 4'h5,
    ALU_SRL    = 4'h6,
    ALU_SRA    = 4'h7,
    ALU_OR     = 4'h8,
    ALU_AND    = 4'h9,
    ALU_ADDW   = 4'hA,
    ALU_SUBW   = 4'hB,
    ALU_SLLW   = 4'hC,
    ALU_SRLW   = 4'hD,
    ALU_SRAW   = 4'hE,
    ALU_PASS_B = 4'hF
  } alu_op_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_RW     = 7'b0111011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_IW     = 7'b0011011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic op1_sel;
    logic op2_sel;
    logic pc_sel;
  } ctrl_t;

endpackage

// File: rtl/alu_branch_control_alu.sv
// Combinational 64-bit ALU; W ops work on the low word and sign-extend bit 31.
module alu_branch_control_alu
  import alu_branch_control_pkg::*;
(
  input  logic [63:0] operand1,
  input  logic [63:0] operand2,
  input  logic [3:0]  alu_op,
  output logic [63:0] result
);

  logic [31:0] word_res;

  always_comb begin
    result   = '0;
    word_res = '0;
    case (alu_op_e'(alu_op))
      ALU_ADD:    result = operand1 + operand2;
      ALU_SUB:    result = operand1 - operand2;
      ALU_SLL:    result = operand1 << operand2[5:0];
      ALU_SLT:    result = ($signed(operand1) < $signed(operand2)) ? 64'd1 : 64'd0;
      ALU_SLTU:   result = (operand1 < operand2) ? 64'd1 : 64'd0;
      ALU_XOR:    result = operand1 ^ operand2;
      ALU_SRL:    result = operand1 >> operand2[5:0];
      ALU_SRA:    result = $signed(operand1) >>> operand2[5:0];
      ALU_OR:     result = operand1 | operand2;
      ALU_AND:    result = operand1 & operand2;
      ALU_ADDW: begin
        word_res = operand1[31:0] + operand2[31:0];
        result   = {{32{word_res[31]}}, word_res};
      end
      ALU_SUBW: begin
        word_res = operand1[31:0] - operand2[31:0];
        result   = {{32{word_res[31]}}, word_res};
      end
      ALU_SLLW: begin
        word_res = operand1[31:0] << operand2[4:0];
        result   = {{32{word_res[31]}}, word_res};
      end
      ALU_SRLW: begin
        word_res = operand1[31:0] >> operand2[4:0];
        result   = {{32{word_res[31]}}, word_res};
      end
      ALU_SRAW: begin
        word_res = $signed(operand1[31:0]) >>> operand2[4:0];
        result   = {{32{word_res[31]}}, word_res};
      end
      ALU_PASS_B: result = operand2;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/alu_branch_control.sv
// Execute stage: control decode, operand select, ALU and branch compare,
// all combinational, captured in one output register (1-cycle latency).
module alu_branch_control
  import alu_branch_control_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_instr,
  input  logic [63:0] pc,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  input  logic [63:0] imm,
  input  logic [3:0]  alu_op,
  output logic [63:0] alu_result,
  output logic        reg_write_control,
  output logic        mem_read_control,
  output logic        mem_write_control,
  output logic        mem_to_reg_control,
  output logic        alu_operand1_control_out,
  output logic        alu_operand2_control_out,
  output logic        pc_sel_out,
  output logic        branch_compare_result
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        unused_instr_bits;
  logic        taken;
  ctrl_t       ctrl;
  logic [63:0] operand1;
  logic [63:0] operand2;
  logic [63:0] alu_out;

  assign opcode            = if_instr[6:0];
  assign funct3            = if_instr[14:12];
  assign unused_instr_bits = ^{if_instr[31:15], if_instr[11:7]};

  always_comb begin
    taken = 1'b0;
    if (opcode == OPC_BRANCH) begin
      case (funct3)
        F3_BEQ:  taken = (rs1_data == rs2_data);
        F3_BNE:  taken = (rs1_data != rs2_data);
        F3_BLT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
        F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
        F3_BLTU: taken = (rs1_data <  rs2_data);
        F3_BGEU: taken = (rs1_data >= rs2_data);
        default: taken = 1'b0;
      endcase
    end
  end

  // Field order: reg_write, mem_read, mem_write, mem_to_reg, op1_sel, op2_sel, pc_sel.
  always_comb begin
    ctrl = '0;
    case (opcode)
      OPC_R, OPC_RW: ctrl = 7'b1000000;
      OPC_I, OPC_IW: ctrl = 7'b1000010;
      OPC_LOAD:      ctrl = 7'b1101010;
      OPC_STORE:     ctrl = 7'b0010010;
      OPC_BRANCH:    ctrl = {6'b000011, taken};
      OPC_JAL:       ctrl = 7'b1000111;
      OPC_JALR:      ctrl = 7'b1000011;
      OPC_LUI:       ctrl = 7'b1000010;
      OPC_AUIPC:     ctrl = 7'b1000110;
      default:       ctrl = '0;
    endcase
  end

  assign operand1 = ctrl.op1_sel ? pc  : rs1_data;
  assign operand2 = ctrl.op2_sel ? imm : rs2_data;

  alu_branch_control_alu u_alu (
    .operand1 (operand1),
    .operand2 (operand2),
    .alu_op   (alu_op),
    .result   (alu_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result               <= '0;
      reg_write_control        <= 1'b0;
      mem_read_control         <= 1'b0;
      mem_write_control        <= 1'b0;
      mem_to_reg_control       <= 1'b0;
      alu_operand1_control_out <= 1'b0;
      alu_operand2_control_out <= 1'b0;
      pc_sel_out               <= 1'b0;
      branch_compare_result    <= 1'b0;
    end else begin
      alu_result               <= alu_out;
      reg_write_control        <= ctrl.reg_write;
      mem_read_control         <= ctrl.mem_read;
      mem_write_control        <= ctrl.mem_write;
      mem_to_reg_control       <= ctrl.mem_to_reg;
      alu_operand1_control_out <= ctrl.op1_sel;
      alu_operand2_control_out <= ctrl.op2_sel;
      pc_sel_out               <= ctrl.pc_sel;
      branch_compare_result    <= taken;
    end
  end

endmodule

// File: tb/tb_alu_branch_control.sv
// Table-driven and randomized bench for alu_branch_control with an expected-value queue.
module tb_alu_branch_control;

  logic        clk;
  logic        reset;
  logic [31:0] if_instr;
  logic [63:0] pc, rs1_data, rs2_data, imm;
  logic [3:0]  alu_op;
  logic [63:0] alu_result;
  logic        reg_write_control, mem_read_control, mem_write_control, mem_to_reg_control;
  logic        alu_operand1_control_out, alu_operand2_control_out, pc_sel_out;
  logic        branch_compare_result;

  int checks = 0;
  int errors = 0;

  // {alu_result, regwr, memrd, memwr, memtoreg, op1, op2, pcsel, taken}
  logic [71:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [63:0] pc;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic [3:0]  op;
    logic [63:0] exp_res;
    logic [7:0]  exp_ctrl;
  } vec_t;

  vec_t vecs[$];

  alu_branch_control dut (
    .clk                      (clk),
    .reset                    (reset),
    .if_instr                 (if_instr),
    .pc                       (pc),
    .rs1_data                 (rs1_data),
    .rs2_data                 (rs2_data),
    .imm                      (imm),
    .alu_op                   (alu_op),
    .alu_result               (alu_result),
    .reg_write_control        (reg_write_control),
    .mem_read_control         (mem_read_control),
    .mem_write_control        (mem_write_control),
    .mem_to_reg_control       (mem_to_reg_control),
    .alu_operand1_control_out (alu_operand1_control_out),
    .alu_operand2_control_out (alu_operand2_control_out),
    .pc_sel_out               (pc_sel_out),
    .branch_compare_result    (branch_compare_result)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] observed();
    return {alu_result, reg_write_control, mem_read_control, mem_write_control,
            mem_to_reg_control, alu_operand1_control_out, alu_operand2_control_out,
            pc_sel_out, branch_compare_result};
  endfunction

  // Independent reference model used for the randomized section.
  function automatic logic [71:0] ref_model(logic [6:0] opc, logic [2:0] f3, logic [63:0] p,
                                            logic [63:0] r1, logic [63:0] r2, logic [63:0] im,
                                            logic [3:0] op);
    logic [6:0]  c;
    logic        tk;
    logic [63:0] a, b, r;
    logic [31:0] w;
    tk = 1'b0;
    if (opc == 7'b1100011) begin
      case (f3)
        3'b000: tk = (r1 == r2);
        3'b001: tk = (r1 != r2);
        3'b100: tk = ($signed(r1) < $signed(r2));
        3'b101: tk = !($signed(r1) < $signed(r2));
        3'b110: tk = (r1 < r2);
        3'b111: tk = !(r1 < r2);
        default: tk = 1'b0;
      endcase
    end
    case (opc)
      7'b0110011, 7'b0111011: c = 7'b1000000;
      7'b0010011, 7'b0011011: c = 7'b1000010;
      7'b0000011:             c = 7'b1101010;
      7'b0100011:             c = 7'b0010010;
      7'b1100011:             c = {6'b000011, tk};
      7'b1101111:             c = 7'b1000111;
      7'b1100111:             c = 7'b1000011;
      7'b0110111:             c = 7'b1000010;
      7'b0010111:             c = 7'b1000110;
      default:                c = 7'b0000000;
    endcase
    a = c[2] ? p : r1;
    b = c[1] ? im : r2;
    w = 32'h0;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a << b[5:0];
      4'h3: r = {63'd0, $signed(a) < $signed(b)};
      4'h4: r = {63'd0, a < b};
      4'h5: r = a ^ b;
      4'h6: r = a >> b[5:0];
      4'h7: r = $signed(a) >>> b[5:0];
      4'h8: r = a | b;
      4'h9: r = a & b;
      4'hA: begin w = a[31:0] + b[31:0];            r = {{32{w[31]}}, w}; end
      4'hB: begin w = a[31:0] - b[31:0];            r = {{32{w[31]}}, w}; end
      4'hC: begin w = a[31:0] << b[4:0];            r = {{32{w[31]}}, w}; end
      4'hD: begin w = a[31:0] >> b[4:0];            r = {{32{w[31]}}, w}; end
      4'hE: begin w = $signed(a[31:0]) >>> b[4:0];  r = {{32{w[31]}}, w}; end
      default: r = b;
    endcase
    return {r, c, tk};
  endfunction

  // Driver tasks
  task automatic add_vec(string n, logic [6:0] opc, logic [2:0] f3, logic [63:0] p,
                         logic [63:0] r1, logic [63:0] r2, logic [63:0] im, logic [3:0] op,
                         logic [63:0] er, logic [7:0] ec);
    vec_t v;
    v.name = n; v.opc = opc; v.f3 = f3; v.pc = p; v.rs1 = r1; v.rs2 = r2; v.imm = im;
    v.op = op; v.exp_res = er; v.exp_ctrl = ec;
    vecs.push_back(v);
  endtask

  task automatic check_out();
    logic [71:0] exp;
    string       n;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h with no expected entry", observed());
    end else begin
      exp = exp_q.pop_front();
      n   = name_q.pop_front();
      if (observed() !== exp) begin
        errors++;
        $display("FAIL %s: got res=%h ctrl=%b, expected res=%h ctrl=%b",
                 n, observed()[71:8], observed()[7:0], exp[71:8], exp[7:0]);
      end
    end
  endtask

  // Drive one set of inputs on the falling edge, expect it one rising edge later.
  task automatic apply(string n, logic rst, logic [6:0] opc, logic [2:0] f3, logic [63:0] p,
                       logic [63:0] r1, logic [63:0] r2, logic [63:0] im, logic [3:0] op,
                       logic [71:0] exp);
    @(negedge clk);
    reset    = rst;
    if_instr = {17'd0, f3, 5'd0, opc};
    pc       = p;
    rs1_data = r1;
    rs2_data = r2;
    imm      = im;
    alu_op   = op;
    exp_q.push_back(rst ? 72'd0 : exp);
    name_q.push_back(n);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    logic [6:0] opc_pool[12];
    logic [6:0] ro;
    logic [2:0] rf;
    logic [63:0] rp, r1, r2, ri;
    logic [3:0] rop;

    opc_pool = '{7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011, 7'b0000011, 7'b0100011,
                 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};

    add_vec("add_ovf",  7'b0110011, 3'b000, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h0,
            64'h8000_0000_0000_0000, 8'b1000_0000);
    add_vec("addw",     7'b0011011, 3'b000, 64'h0, 64'h0000_0000_7FFF_FFFF, 64'd0, 64'd1, 4'hA,
            64'hFFFF_FFFF_8000_0000, 8'b1000_0100);
    add_vec("blt",      7'b1100011, 3'b100, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 4'h0,
            64'h120, 8'b0000_1111);
    add_vec("bltu",     7'b1100011, 3'b110, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 4'h0,
            64'h120, 8'b0000_1100);
    add_vec("beq",      7'b1100011, 3'b000, 64'h200, 64'd5, 64'd5, 64'h8, 4'h0, 64'h208, 8'b0000_1111);
    add_vec("bne",      7'b1100011, 3'b001, 64'h200, 64'd5, 64'd5, 64'h8, 4'h0, 64'h208, 8'b0000_1100);
    add_vec("bge",      7'b1100011, 3'b101, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h4, 4'h0,
            64'h4, 8'b0000_1100);
    add_vec("bgeu",     7'b1100011, 3'b111, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h4, 4'h0,
            64'h4, 8'b0000_1111);
    add_vec("br_f3_010", 7'b1100011, 3'b010, 64'h0, 64'd1, 64'd1, 64'h4, 4'h0, 64'h4, 8'b0000_1100);
    add_vec("load",     7'b0000011, 3'b011, 64'h0, 64'h1000, 64'd0, 64'd8, 4'h0, 64'h1008, 8'b1101_0100);
    add_vec("store",    7'b0100011, 3'b011, 64'h0, 64'h2000, 64'd9, 64'hFFFF_FFFF_FFFF_FFFC, 4'h0,
            64'h1FFC, 8'b0010_0100);
    add_vec("sra63",    7'b0110011, 3'b101, 64'h0, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 4'h7,
            64'hFFFF_FFFF_FFFF_FFFF, 8'b1000_0000);
    add_vec("illegal",  7'b0000000, 3'b000, 64'h40, 64'd5, 64'd3, 64'd100, 4'h0, 64'd8, 8'b0000_0000);
    add_vec("jal",      7'b1101111, 3'b000, 64'h400, 64'd7, 64'd7, 64'h10, 4'h0, 64'h410, 8'b1000_1110);
    add_vec("jalr",     7'b1100111, 3'b000, 64'h400, 64'h800, 64'd7, 64'h4, 4'h0, 64'h804, 8'b1000_0110);
    add_vec("lui",      7'b0110111, 3'b000, 64'h400, 64'd7, 64'd7, 64'h1234_5000, 4'hF,
            64'h1234_5000, 8'b1000_0100);
    add_vec("auipc",    7'b0010111, 3'b000, 64'h1000, 64'd7, 64'd7, 64'h2000, 4'h0, 64'h3000, 8'b1000_1100);
    add_vec("subw",     7'b0111011, 3'b000, 64'h0, 64'd0, 64'd1, 64'd0, 4'hB,
            64'hFFFF_FFFF_FFFF_FFFF, 8'b1000_0000);
    add_vec("slt",      7'b0110011, 3'b010, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h3,
            64'd1, 8'b1000_0000);
    add_vec("sltu",     7'b0110011, 3'b011, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h4,
            64'd0, 8'b1000_0000);
    add_vec("sllw31",   7'b0111011, 3'b001, 64'h0, 64'd1, 64'd31, 64'd0, 4'hC,
            64'hFFFF_FFFF_8000_0000, 8'b1000_0000);
    add_vec("srlw",     7'b0111011, 3'b101, 64'h0, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'd0, 4'hD,
            64'h0000_0000_0800_0000, 8'b1000_0000);
    add_vec("sraw",     7'b0111011, 3'b101, 64'h0, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'd0, 4'hE,
            64'hFFFF_FFFF_F800_0000, 8'b1000_0000);
    add_vec("sll_mask", 7'b0110011, 3'b001, 64'h0, 64'd1, 64'd65, 64'd0, 4'h2, 64'd2, 8'b1000_0000);
    add_vec("srl",      7'b0110011, 3'b101, 64'h0, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 4'h6,
            64'h0800_0000_0000_0000, 8'b1000_0000);
    add_vec("sub",      7'b0110011, 3'b000, 64'h0, 64'd5, 64'd7, 64'd0, 4'h1,
            64'hFFFF_FFFF_FFFF_FFFE, 8'b1000_0000);
    add_vec("xor",      7'b0010011, 3'b100, 64'h0, 64'hF0F0, 64'd0, 64'hFF00, 4'h5, 64'h0FF0, 8'b1000_0100);
    add_vec("or",       7'b0110011, 3'b110, 64'h0, 64'hF0F0, 64'h0F00, 64'd0, 4'h8, 64'hFFF0, 8'b1000_0000);
    add_vec("and",      7'b0110011, 3'b111, 64'h0, 64'hF0F0, 64'hFF00, 64'd0, 4'h9, 64'hF000, 8'b1000_0000);

    reset = 1'b1; if_instr = '0; pc = '0; rs1_data = '0; rs2_data = '0; imm = '0; alu_op = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (observed() !== 72'd0) begin
      errors++;
      $display("FAIL reset_state: got %h, expected 0", observed());
    end

    // Directed table, back to back one per cycle
    foreach (vecs[i])
      apply(vecs[i].name, 1'b0, vecs[i].opc, vecs[i].f3, vecs[i].pc, vecs[i].rs1, vecs[i].rs2,
            vecs[i].imm, vecs[i].op, {vecs[i].exp_res, vecs[i].exp_ctrl});

    // Reset mid-stream with a live instruction, then the same instruction after release
    apply("pre_reset", 1'b0, 7'b0110011, 3'b000, 64'h0, 64'd10, 64'd20, 64'd0, 4'h0,
          {64'd30, 8'b1000_0000});
    apply("mid_reset", 1'b1, 7'b1101111, 3'b000, 64'h400, 64'd0, 64'd0, 64'h10, 4'h0, 72'd0);
    apply("mid_reset2", 1'b1, 7'b0000011, 3'b000, 64'h0, 64'h1000, 64'd0, 64'd8, 4'h0, 72'd0);
    apply("post_reset", 1'b0, 7'b1101111, 3'b000, 64'h400, 64'd0, 64'd0, 64'h10, 4'h0,
          {64'h410, 8'b1000_1110});

    // Randomized sweep against the reference model
    for (int i = 0; i < 300; i++) begin
      ro  = opc_pool[$urandom_range(0, 11)];
      rf  = 3'($urandom_range(0, 7));
      rop = 4'($urandom_range(0, 15));
      rp  = {$urandom, $urandom};
      r1  = {$urandom, $urandom};
      r2  = ($urandom_range(0, 3) == 0) ? r1 : {$urandom, $urandom};
      ri  = {$urandom, $urandom};
      apply("random", 1'b0, ro, rf, rp, r1, r2, ri, rop, ref_model(ro, rf, rp, r1, r2, ri, rop));
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
